// File: rtl/axis_sink_pkg.sv
// Shared types and helpers for the AXI4-Stream frame sink.
package axis_sink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECEIVE = 2'b01,
    DRAIN   = 2'b10
  } state_t;

  // Pointers must be able to hold N itself (one past the last buffer slot).
  function automatic int ptr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axis_sink_buf.sv
// Frame buffer: DEPTH x DW register array, synchronous write, asynchronous read.
module axis_sink_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_stream_sink.sv
// AXI4-Stream slave capturing fixed-length frames with a show-ahead drain port.
// Optional beat pattern checker enabled by defining AXIS_SINK_PATTERN_CHECK_EN.
//
// state   | meaning
// IDLE    | clear pointers and error flags, TREADY low
// RECEIVE | TREADY high, accept beats until TLAST or beat N-1
// DRAIN   | TREADY low, local logic pops captured words
module axis_stream_sink
  import axis_sink_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH  = 32,
  parameter int NUMBER_OF_INPUT_WORDS = 8,
  parameter int C_PATTERN_BASE        = 1
) (
  input  logic                                       S_AXIS_ACLK,
  input  logic                                       S_AXIS_ARESETN,
  output logic                                       S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]            S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]          S_AXIS_TSTRB,
  input  logic                                       S_AXIS_TLAST,
  input  logic                                       S_AXIS_TVALID,
  input  logic                                       rd_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]            rd_data,
  output logic                                       rd_valid,
  output logic                                       frame_done,
  output logic [$clog2(NUMBER_OF_INPUT_WORDS+1)-1:0] word_count,
  output logic                                       tlast_err,
  output logic                                       data_err
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int N  = NUMBER_OF_INPUT_WORDS;
  localparam int PW = ptr_width(N);
  localparam int AW = $clog2(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  state_t        state, next_state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          accept, close, early_last, missing_last, pop;
  logic [W-1:0]  buf_rd_data;
  logic          unused_tstrb;

  assign unused_tstrb = ^S_AXIS_TSTRB;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state <= IDLE;
    else                 state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = RECEIVE;
      RECEIVE: if (close) next_state = DRAIN;
      DRAIN:   if (rd_ptr == wr_ptr) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept       = 1'b0;
    close        = 1'b0;
    early_last   = 1'b0;
    missing_last = 1'b0;
    rd_valid     = 1'b0;
    pop          = 1'b0;
    case (state)
      RECEIVE: begin
        accept       = S_AXIS_TVALID && S_AXIS_TREADY;
        close        = accept && (S_AXIS_TLAST || (wr_ptr == LAST_IDX));
        early_last   = accept && S_AXIS_TLAST && (wr_ptr != LAST_IDX);
        missing_last = accept && !S_AXIS_TLAST && (wr_ptr == LAST_IDX);
      end
      DRAIN: begin
        rd_valid = (rd_ptr < wr_ptr);
        pop      = rd_en && rd_valid;
      end
      default: ;
    endcase
  end

  // TREADY is registered from next_state so it tracks RECEIVE exactly.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      S_AXIS_TREADY <= 1'b0;
      frame_done    <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tlast_err     <= 1'b0;
    end else begin
      S_AXIS_TREADY <= (next_state == RECEIVE);
      frame_done    <= close;
      if (state == IDLE) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        tlast_err <= 1'b0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + PW'(1);
        if (pop)    rd_ptr <= rd_ptr + PW'(1);
        if (early_last || missing_last) tlast_err <= 1'b1;
      end
    end
  end

  axis_sink_buf #(
    .DW    (W),
    .DEPTH (N),
    .AW    (AW)
  ) u_buf (
    .clk     (S_AXIS_ACLK),
    .wr_en   (accept),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (S_AXIS_TDATA),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (buf_rd_data)
  );

  // rd_ptr may sit at N once drained; masking keeps the aliased slot invisible.
  assign rd_data    = rd_valid ? buf_rd_data : '0;
  assign word_count = wr_ptr;

`ifdef AXIS_SINK_PATTERN_CHECK_EN
  logic [W-1:0] expected_beat;

  assign expected_beat = W'(C_PATTERN_BASE) + W'(wr_ptr);

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN)                                   data_err <= 1'b0;
    else if (state == IDLE)                                data_err <= 1'b0;
    else if (accept && (S_AXIS_TDATA != expected_beat))    data_err <= 1'b1;
  end
`else
  logic [W-1:0] unused_pattern_base;

  assign unused_pattern_base = W'(C_PATTERN_BASE);
  assign data_err            = 1'b0;
`endif

endmodule
